rsa_host_bridge: RTL and testbench

Host-side front end for the RSA interface stage. It accepts a 32-bit valid/ready word stream from the host, packs the words into the six 512-bit beats the RSA interface consumes on its `lcl_dout`/`lcl_dv` port, then captures the two 512-bit result beats returned on `lcl_din`/`lcl_den`. It acknowledges the result with `lcl_idone` and streams the result back to the host as 32 words.

---
 rtl/rsa_bridge_pkg.sv | 26 ++
 rtl/rsa_host_bridge_if.sv | 27 ++
 rtl/rsa_beat_packer.sv | 38 +++
 rtl/rsa_host_bridge.sv | 145 ++++++++++++++
 tb/tb_rsa_host_bridge.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/rsa_bridge_pkg.sv
// Shared types and sizing for the RSA host bridge: state encoding, beat geometry and
// a word-select helper used when unpacking result beats.
package rsa_bridge_pkg;

    localparam int unsigned WORDS_PER_BEAT = 16;
    localparam int unsigned BEATS_IN       = 6;
    localparam int unsigned BEATS_OUT      = 2;
    localparam int unsigned HOST_W         = 32;
    localparam int unsigned BEAT_W         = 512;
    localparam int unsigned WORDS_IN       = WORDS_PER_BEAT * BEATS_IN;
    localparam int unsigned WORDS_OUT      = WORDS_PER_BEAT * BEATS_OUT;

    typedef enum logic [2:0] {
        StLoad,
        StWaitRes,
        StCapture,
        StAck,
        StDrain
    } state_e;

    function automatic logic [HOST_W-1:0] beat_word(input logic [BEAT_W-1:0] beat,
                                                    input logic [3:0]        idx);
        return beat[idx*HOST_W +: HOST_W];
    endfunction

endpackage

// File: rtl/rsa_host_bridge_if.sv
// Host word stream plus RSA-stage beat port. master = bridge side, slave = environment.
interface rsa_host_bridge_if;
    import rsa_bridge_pkg::*;

    logic [HOST_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic [HOST_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [BEAT_W-1:0] lcl_dout;
    logic              lcl_dv;
    logic [BEAT_W-1:0] lcl_din;
    logic              lcl_den;
    logic              lcl_idone;

    modport master (
        input  s_data, s_valid, m_ready, lcl_din, lcl_den,
        output s_ready, m_data, m_valid, lcl_dout, lcl_dv, lcl_idone
    );

    modport slave (
        output s_data, s_valid, m_ready, lcl_din, lcl_den,
        input  s_ready, m_data, m_valid, lcl_dout, lcl_dv, lcl_idone
    );

endinterface

// File: rtl/rsa_beat_packer.sv
// Packs 32-bit host words into a 512-bit beat, first word least significant.
// beat already includes the word being accepted, so the caller can register it on beat_done.
module rsa_beat_packer
    import rsa_bridge_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [HOST_W-1:0] word,
    input  logic              word_valid,
    output logic [BEAT_W-1:0] beat,
    output logic              beat_done
);

    logic [BEAT_W-1:0] pack_q, pack_d;
    logic [3:0]        idx_q, idx_d;

    always_comb begin
        pack_d = pack_q;
        pack_d[idx_q*HOST_W +: HOST_W] = word;
        idx_d = word_valid ? idx_q + 4'd1 : idx_q;
    end

    assign beat      = pack_d;
    assign beat_done = word_valid && (idx_q == 4'(WORDS_PER_BEAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack_q <= '0;
            idx_q  <= '0;
        end else begin
            idx_q <= idx_d;
            if (word_valid) begin
                pack_q <= pack_d;
            end
        end
    end

endmodule

// File: rtl/rsa_host_bridge.sv
// Host front end for the RSA stage: packs 96 host words into six operand beats, waits for
// the two-beat result, acknowledges it and streams it back to the host as 32 words.
module rsa_host_bridge
    import rsa_bridge_pkg::*;
#(
    parameter int unsigned RESULT_TIMEOUT = 1 << 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rsa_host_bridge_if.master     bus,
    output logic                  busy,
    output logic                  err_timeout
);

    localparam int unsigned TW = $clog2(RESULT_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [6:0]        wcnt_q, wcnt_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [4:0]        rcnt_q, rcnt_d;
    logic              err_q, err_d;
    logic              s_ready_q;
    logic              den_q;
    logic [BEAT_W-1:0] res0_q, res1_q;
    logic [BEAT_W-1:0] dout_q;
    logic              dv_q;
    logic              cap0, cap1;
    logic              accept;
    logic [BEAT_W-1:0] beat;
    logic              beat_done;
    logic [HOST_W-1:0] drain_word;

    // s_ready_q is only ever high in LOAD, so it alone qualifies an accept.
    assign accept = bus.s_valid && s_ready_q;

    rsa_beat_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .word       (bus.s_data),
        .word_valid (accept),
        .beat       (beat),
        .beat_done  (beat_done)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        rcnt_d  = rcnt_q;
        err_d   = err_q;
        cap0    = 1'b0;
        cap1    = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (accept) begin
                    if (wcnt_q == 7'(WORDS_IN - 1)) begin
                        wcnt_d  = '0;
                        tcnt_d  = '0;
                        state_d = StWaitRes;
                    end else begin
                        wcnt_d = wcnt_q + 7'd1;
                    end
                end
            end
            StWaitRes: begin
                // Only a fresh rise counts; a level left high from before entry is ignored.
                if (bus.lcl_den && !den_q) begin
                    cap0    = 1'b1;
                    state_d = StCapture;
                end else if (tcnt_q == TW'(RESULT_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StLoad;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            StCapture: begin
                cap1    = 1'b1;
                state_d = StAck;
            end
            StAck: begin
                rcnt_d  = '0;
                state_d = StDrain;
            end
            StDrain: begin
                if (bus.m_ready) begin
                    if (rcnt_q == 5'(WORDS_OUT - 1)) begin
                        rcnt_d  = '0;
                        state_d = StLoad;
                    end else begin
                        rcnt_d = rcnt_q + 5'd1;
                    end
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLoad;
            wcnt_q    <= '0;
            tcnt_q    <= '0;
            rcnt_q    <= '0;
            err_q     <= 1'b0;
            s_ready_q <= 1'b0;
            den_q     <= 1'b0;
            res0_q    <= '0;
            res1_q    <= '0;
            dout_q    <= '0;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            tcnt_q    <= tcnt_d;
            rcnt_q    <= rcnt_d;
            err_q     <= err_d;
            s_ready_q <= (state_d == StLoad);
            den_q     <= bus.lcl_den;
            dv_q      <= beat_done;
            if (beat_done) begin
                dout_q <= beat;
            end
            if (cap0) begin
                res0_q <= bus.lcl_din;
            end
            if (cap1) begin
                res1_q <= bus.lcl_din;
            end
        end
    end

    assign drain_word = rcnt_q[4] ? beat_word(res1_q, rcnt_q[3:0])
                                  : beat_word(res0_q, rcnt_q[3:0]);

    assign bus.s_ready   = s_ready_q;
    assign bus.m_valid   = (state_q == StDrain);
    assign bus.m_data    = (state_q == StDrain) ? drain_word : '0;
    assign bus.lcl_dout  = dout_q;
    assign bus.lcl_dv    = dv_q;
    assign bus.lcl_idone = (state_q == StAck);
    assign busy          = !((state_q == StLoad) && (wcnt_q == 7'd0));
    assign err_timeout   = err_q;

endmodule

// File: tb/tb_rsa_host_bridge.sv
// Directed bench for rsa_host_bridge: reset, dense and gapped loads, result capture and
// drain with backpressure, result timeout, and reset in the middle of a load.
module tb_rsa_host_bridge;

    localparam int unsigned TO = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    logic err_timeout;

    rsa_host_bridge_if bus ();

    rsa_host_bridge #(.RESULT_TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int n_chk = 0;
    logic [511:0] beats[$];
    logic [511:0] exp_beats[$];
    int dv_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.lcl_dv === 1'b1) begin
            beats.push_back(bus.lcl_dout);
            dv_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives 96 words base+i; model beat b word k = base + 16b + k.
    task automatic load_job(input logic [31:0] base, input bit gapped);
        int i = 0;
        int budget = 0;
        logic [511:0] e;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 16; k++) e[32*k +: 32] = base + 32'(16*b + k);
            exp_beats.push_back(e);
        end
        while (i < 96 && budget < 2000) begin
            bus.s_valid = gapped ? ($urandom_range(0, 2) != 0) : 1'b1;
            bus.s_data  = base + 32'(i);
            if (bus.s_valid && bus.s_ready) i++;
            step();
            budget++;
        end
        bus.s_valid = 1'b0;
        check("load_words", 512'(i), 512'(96));
        check("last_dv", 512'(bus.lcl_dv), 512'(1));
        check("ready_low_wait", 512'(bus.s_ready), 512'(0));
        check("busy_wait", 512'(busy), 512'(1));
    endtask

    task automatic check_beats(input bit dense);
        check("beat_count", 512'(beats.size()), 512'(exp_beats.size()));
        for (int j = n_chk; j < exp_beats.size(); j++) begin
            check("beat", beats[j], exp_beats[j]);
            if (dense && j > n_chk) check("dv_spacing", 512'(dv_cyc[j] - dv_cyc[j-1]), 512'(16));
        end
        n_chk = exp_beats.size();
    endtask

    task automatic give_result(input logic [31:0] lo, input logic [31:0] hi);
        logic [511:0] d0, d1;
        for (int k = 0; k < 16; k++) begin
            d0[32*k +: 32] = lo + 32'(k);
            d1[32*k +: 32] = hi + 32'(k);
        end
        bus.lcl_din = d0;
        bus.lcl_den = 1'b1;
        step();
        check("idone_rise1", 512'(bus.lcl_idone), 512'(0));
        bus.lcl_din = d1;
        step();
        check("idone_rise2", 512'(bus.lcl_idone), 512'(1));
        check("mvalid_ack", 512'(bus.m_valid), 512'(0));
        bus.lcl_den = 1'b0;
        bus.lcl_din = '0;
        step();
        check("idone_rise3", 512'(bus.lcl_idone), 512'(0));
        check("mvalid_first", 512'(bus.m_valid), 512'(1));
    endtask

    task automatic drain(input logic [31:0] lo, input logic [31:0] hi, input bit toggle);
        int idx = 0;
        int budget = 0;
        bit stalled;
        logic [31:0] hold;
        logic [31:0] e;
        while (idx < 32 && budget < 500) begin
            bus.m_ready = toggle ? 1'($urandom_range(0, 1)) : 1'b1;
            e = (idx < 16) ? lo + 32'(idx) : hi + 32'(idx - 16);
            check("drain_valid", 512'(bus.m_valid), 512'(1));
            check("drain_data", 512'(bus.m_data), 512'(e));
            hold = bus.m_data;
            stalled = !bus.m_ready;
            if (bus.m_ready) idx++;
            step();
            budget++;
            if (stalled) check("stall_hold", 512'(bus.m_data), 512'(hold));
        end
        bus.m_ready = 1'b0;
        check("drain_words", 512'(idx), 512'(32));
        check("drain_done_valid", 512'(bus.m_valid), 512'(0));
        check("drain_done_ready", 512'(bus.s_ready), 512'(1));
    endtask

    initial begin
        logic [511:0] tmp;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b0;
        bus.lcl_din = '0;
        bus.lcl_den = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", 512'(bus.s_ready), 512'(0));
        check("rst_m_valid", 512'(bus.m_valid), 512'(0));
        check("rst_m_data", 512'(bus.m_data), 512'(0));
        check("rst_lcl_dout", bus.lcl_dout, 512'(0));
        check("rst_lcl_dv", 512'(bus.lcl_dv), 512'(0));
        check("rst_lcl_idone", 512'(bus.lcl_idone), 512'(0));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_err", 512'(err_timeout), 512'(0));
        rst_n = 1'b1;
        check("ready_pre_edge", 512'(bus.s_ready), 512'(0));
        step();
        check("ready_after_edge", 512'(bus.s_ready), 512'(1));
        check("busy_idle", 512'(busy), 512'(0));

        // Job 1: dense load of 0..95, then result 0x1000/0x2000 with m_ready held high.
        load_job(32'h0, 1'b0);
        step();
        step();
        give_result(32'h1000, 32'h2000);
        tmp = beats[0];
        check("beat0_lo", 512'(tmp[31:0]), 512'(0));
        check("beat0_hi", 512'(tmp[511:480]), 512'(15));
        tmp = beats[5];
        check("beat5_hi", 512'(tmp[511:480]), 512'(95));
        drain(32'h1000, 32'h2000, 1'b0);
        check_beats(1'b1);

        // Job 2: gapped s_valid and toggling m_ready.
        load_job(32'hA000_0000, 1'b1);
        step();
        give_result(32'h3000, 32'h4000);
        drain(32'h3000, 32'h4000, 1'b1);
        check_beats(1'b0);

        // Job 3: no result; timeout fires exactly TO cycles after WAIT_RES entry.
        load_job(32'h5000, 1'b0);
        repeat (TO - 1) step();
        check("err_before_to", 512'(err_timeout), 512'(0));
        check("ready_before_to", 512'(bus.s_ready), 512'(0));
        step();
        check("err_at_to", 512'(err_timeout), 512'(1));
        step();
        check("ready_after_to", 512'(bus.s_ready), 512'(1));
        check_beats(1'b1);

        // Job 4: normal job, sticky flag survives it.
        load_job(32'h6000, 1'b0);
        check("err_sticky_load", 512'(err_timeout), 512'(1));
        step();
        give_result(32'h7000, 32'h8000);
        drain(32'h7000, 32'h8000, 1'b0);
        check("err_sticky_drain", 512'(err_timeout), 512'(1));
        check_beats(1'b1);

        // Reset after 40 words of a load.
        for (int i = 0; i < 40; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 32'h9000 + 32'(i);
            step();
        end
        bus.s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_dout", bus.lcl_dout, 512'(0));
        check("midrst_ready", 512'(bus.s_ready), 512'(0));
        check("midrst_busy", 512'(busy), 512'(0));
        check("midrst_err", 512'(err_timeout), 512'(0));
        step();
        rst_n = 1'b1;
        beats.delete();
        exp_beats.delete();
        dv_cyc.delete();
        n_chk = 0;
        step();

        // Stale lcl_den high through WAIT_RES entry must not start a capture.
        bus.lcl_den = 1'b1;
        bus.lcl_din = {16{32'hDEAD_BEEF}};
        load_job(32'hB000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stale_idone", 512'(bus.lcl_idone), 512'(0));
            check("stale_mvalid", 512'(bus.m_valid), 512'(0));
        end
        bus.lcl_den = 1'b0;
        step();
        give_result(32'hC000, 32'hD000);
        drain(32'hC000, 32'hD000, 1'b0);
        check_beats(1'b1);
        check("beats_after_reset", 512'(beats.size()), 512'(6));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
